maze_path_player: RTL and testbench
===================================

// Module: maze_path_player
// PURPOSE
//   Reads back the move stack written by the maze solver and replays it, bottom to top, as a
//   stream of 2-bit moves over a valid/ready handshake. Tracks {row,col} while replaying; flags
//   done when the walk ends on DEST_ADDR and fail on a wall crossing or wrong endpoint. Sits
//   between the solver's move-stack RAM and downstream consumers (display, robot driver).
// PARAMETERS
//   ADDR_WIDTH  8               cell address width; grid is 2**(ADDR_WIDTH/2) square, addr={row,col}
//   DEST_ADDR   2**ADDR_WIDTH-1 cell the replayed path must end on
//   START_ADDR  0               cell the replay starts from
// PORTS
//   clk         in   1             single clock, rising edge
//   rst         in   1             synchronous, active-high reset
//   run         in   1             pulse: start replay (sampled in IDLE/DONE/FAIL only)
//   depth       in   ADDR_WIDTH+1  number of valid stack entries, 0..2**ADDR_WIDTH, sampled on run
//   rd_en       out  1             stack RAM read strobe
//   rd_addr     out  ADDR_WIDTH    stack RAM read index
//   rd_data     in   2             stack RAM data, valid the cycle after rd_en
//   move        out  2             00 up(row-1) 01 right(col+1) 10 left(col-1) 11 down(row+1)
//   move_valid  out  1             move is presented
//   move_ready  in   1             consumer accepts move
//   pos         out  ADDR_WIDTH    current {row,col}
//   busy        out  1             replay in progress
//   done        out  1             level: path ended on DEST_ADDR
//   fail        out  1             level: illegal move or wrong endpoint
// BEHAVIOUR
//   - Reset: state=IDLE, rd_en=0, rd_addr=0, move=0, move_valid=0, pos=START_ADDR, busy=done=fail=0.
//   - FSM: IDLE, FETCH, WAIT, PRESENT, CHECK, DONE, FAIL.
//   - IDLE/DONE/FAIL + run: latch depth, idx=0, pos=START_ADDR, clear done/fail, busy=1;
//     depth==0 -> CHECK, else FETCH. run ignored in any other state.
//   - FETCH (1 cycle): rd_en=1, rd_addr=idx -> WAIT.
//   - WAIT (1 cycle): register rd_data into move; if move would leave the grid (row/col underflow
//     or exceed 2**(ADDR_WIDTH/2)-1; no wrap-around) -> FAIL without asserting move_valid;
//     else -> PRESENT. Latency run->first move_valid = 3 cycles.
//   - PRESENT: move_valid=1, move/pos stable until move_ready. On move_valid&&move_ready: pos
//     updated to the new cell, idx++; idx+1==depth -> CHECK else FETCH. Back-to-back moves
//     therefore need 3 cycles each; move_valid never drops without a handshake.
//   - CHECK (1 cycle): pos==DEST_ADDR -> DONE else FAIL.
//   - DONE/FAIL: busy=0, done or fail held high, pos frozen, until run or rst.
//   - done and fail are never high together; exactly one asserts per completed replay.
//   - rst in any state aborts immediately to reset values; partial replay is discarded.
//   - depth > 2**ADDR_WIDTH is clamped to 2**ADDR_WIDTH.
// CONFIGURATION
//   MAZE_PLAYER_REVERSE_EN: adds input 'reverse' (1 bit, sampled on run). reverse=1 replays
//   top to bottom (idx starts at depth-1, decrements), starts at DEST_ADDR, outputs each move
//   inverted (up<->down, left<->right) and checks for START_ADDR at the end. Without the
//   macro the port is absent and only forward replay exists.
// TESTING
//   1. depth=0, DEST_ADDR=0 -> CHECK then done=1 two cycles after run, no move_valid ever.
//   2. 15x right then 15x down, ready tied 1 -> 30 handshakes, pos=8'hFF, done=1, fail=0.
//   3. stack[0]=up (00) from (0,0) -> fail=1, move_valid never asserted, pos stays 0.
//   4. Valid path, move_ready low 5 cycles in PRESENT -> move_valid, move, pos stable; then accept.
//   5. 10 rights only, DEST_ADDR=8'hFF -> 10 moves, pos=8'h0A, fail=1; run again -> fail clears.
//   6. rst asserted mid-PRESENT -> next cycle all outputs at reset values; run restarts at idx 0.

Source files
------------

// File: rtl/maze_path_player.sv
// Replays the maze solver's move stack as a valid/ready stream of 2-bit moves while tracking
// {row,col}. Optional macro MAZE_PLAYER_REVERSE_EN adds top-to-bottom replay with inverted moves.
module maze_path_player #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] DEST_ADDR  = {ADDR_WIDTH{1'b1}},
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [ADDR_WIDTH:0]   depth,
`ifdef MAZE_PLAYER_REVERSE_EN
  input  logic                  reverse,
`endif
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [1:0]            rd_data,
  output logic [1:0]            move,
  output logic                  move_valid,
  input  logic                  move_ready,
  output logic [ADDR_WIDTH-1:0] pos,
  output logic                  busy,
  output logic                  done,
  output logic                  fail
);

  localparam int unsigned         HalfW    = ADDR_WIDTH / 2;
  localparam logic [HalfW-1:0]    CoordMax = {HalfW{1'b1}};
  localparam logic [ADDR_WIDTH:0] MaxDepth = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StPresent, StCheck, StDone, StFail
  } state_e;

  function automatic logic legal_move(input logic [ADDR_WIDTH-1:0] p, input logic [1:0] m);
    logic [HalfW-1:0] row, col;
    row = p[2*HalfW-1:HalfW];
    col = p[HalfW-1:0];
    case (m)
      2'b00:   legal_move = (row != '0);
      2'b01:   legal_move = (col != CoordMax);
      2'b10:   legal_move = (col != '0);
      default: legal_move = (row != CoordMax);
    endcase
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] step_pos(input logic [ADDR_WIDTH-1:0] p,
                                                     input logic [1:0] m);
    logic [HalfW-1:0] row, col;
    row = p[2*HalfW-1:HalfW];
    col = p[HalfW-1:0];
    case (m)
      2'b00:   row = row - 1'b1;
      2'b01:   col = col + 1'b1;
      2'b10:   col = col - 1'b1;
      default: row = row + 1'b1;
    endcase
    step_pos = {row, col};
  endfunction

  state_e                state_q, state_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]            move_q, move_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] pos_q, pos_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   left_q, left_d;  // moves still to be handed off
  logic                  rev_q, rev_d;
  logic [ADDR_WIDTH:0]   dep_clamp;
  logic [1:0]            mv_in;
  logic                  req_rev;

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    move_d    = move_q;
    valid_d   = valid_q;
    pos_d     = pos_q;
    busy_d    = busy_q;
    done_d    = done_q;
    fail_d    = fail_q;
    idx_d     = idx_q;
    left_d    = left_q;
    rev_d     = rev_q;
    dep_clamp = (depth > MaxDepth) ? MaxDepth : depth;
    // Reverse replay walks the path backwards, so every move is mirrored (00<->11, 01<->10).
    mv_in     = rev_q ? ~rd_data : rd_data;
`ifdef MAZE_PLAYER_REVERSE_EN
    req_rev   = reverse;
`else
    req_rev   = 1'b0;
`endif

    unique case (state_q)
      StIdle, StDone, StFail: begin
        if (run) begin
          rev_d  = req_rev;
          left_d = dep_clamp;
          idx_d  = req_rev ? ADDR_WIDTH'(dep_clamp - 1'b1) : '0;
          pos_d  = req_rev ? DEST_ADDR : START_ADDR;
          done_d = 1'b0;
          fail_d = 1'b0;
          busy_d = 1'b1;
          if (dep_clamp == '0) begin
            state_d = StCheck;
          end else begin
            state_d   = StFetch;
            rd_en_d   = 1'b1;
            rd_addr_d = idx_d;
          end
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        move_d = mv_in;
        if (!legal_move(pos_q, mv_in)) begin
          state_d = StFail;
          fail_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = StPresent;
          valid_d = 1'b1;
        end
      end
      StPresent: begin
        if (move_ready) begin
          valid_d = 1'b0;
          pos_d   = step_pos(pos_q, move_q);
          left_d  = left_q - 1'b1;
          idx_d   = rev_q ? idx_q - 1'b1 : idx_q + 1'b1;
          if (left_q == (ADDR_WIDTH+1)'(1)) begin
            state_d = StCheck;
          end else begin
            state_d   = StFetch;
            rd_en_d   = 1'b1;
            rd_addr_d = idx_d;
          end
        end
      end
      StCheck: begin
        busy_d = 1'b0;
        if (pos_q == (rev_q ? START_ADDR : DEST_ADDR)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d = StFail;
          fail_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      move_q    <= 2'b00;
      valid_q   <= 1'b0;
      pos_q     <= START_ADDR;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      idx_q     <= '0;
      left_q    <= '0;
      rev_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      move_q    <= move_d;
      valid_q   <= valid_d;
      pos_q     <= pos_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      idx_q     <= idx_d;
      left_q    <= left_d;
      rev_q     <= rev_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign move       = move_q;
  assign move_valid = valid_q;
  assign pos        = pos_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;

endmodule

// File: tb/tb_maze_path_player.sv
// Randomized bench for maze_path_player: a grid-walk reference model predicts every handshake,
// the final cell and the done/fail outcome; a second instance with DEST_ADDR=0 covers empty replays.
module tb_maze_path_player;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst, run, move_ready;
  logic [AW:0]   depth;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_data;
  logic [1:0]    move;
  logic          move_valid, busy, done, fail;
  logic [AW-1:0] pos;

  logic          d0_rd_en, d0_valid, d0_busy, d0_done, d0_fail;
  logic [AW-1:0] d0_rd_addr, d0_pos;
  logic [1:0]    d0_move;

  logic [1:0]    mem [256];
  int            n_chk = 0;
  int            n_pass = 0;
  int            exp_mv[$];
  int            exp_pb[$];

  always #5 clk = ~clk;

  always_ff @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  maze_path_player #(.ADDR_WIDTH(AW)) u_dut (
    .clk(clk), .rst(rst), .run(run), .depth(depth),
`ifdef MAZE_PLAYER_REVERSE_EN
    .reverse(1'b0),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .move(move),
    .move_valid(move_valid), .move_ready(move_ready), .pos(pos),
    .busy(busy), .done(done), .fail(fail)
  );

  maze_path_player #(.ADDR_WIDTH(AW), .DEST_ADDR(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .run(run), .depth(depth),
`ifdef MAZE_PLAYER_REVERSE_EN
    .reverse(1'b0),
`endif
    .rd_en(d0_rd_en), .rd_addr(d0_rd_addr), .rd_data(2'b00), .move(d0_move),
    .move_valid(d0_valid), .move_ready(1'b1), .pos(d0_pos),
    .busy(d0_busy), .done(d0_done), .fail(d0_fail)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit legal(int r, int c, int m);
    case (m)
      0:       return r > 0;
      1:       return c < 15;
      2:       return c > 0;
      default: return r < 15;
    endcase
  endfunction

  // Reference: walk the grid from (0,0) with plain integers.
  task automatic model(input int n, output int hs, output bit dn, output int p);
    int r = 0;
    int c = 0;
    exp_mv.delete();
    exp_pb.delete();
    hs = 0;
    for (int i = 0; i < n; i++) begin
      int m = int'(mem[i]);
      if (!legal(r, c, m)) begin
        dn = 1'b0;
        p  = r * 16 + c;
        return;
      end
      exp_mv.push_back(m);
      exp_pb.push_back(r * 16 + c);
      hs++;
      case (m)
        0:       r--;
        1:       c++;
        2:       c--;
        default: r++;
      endcase
    end
    dn = (r == 15) && (c == 15);
    p  = r * 16 + c;
  endtask

  task automatic gen_walk(input int len, input int bad_pct);
    int r = 0;
    int c = 0;
    for (int i = 0; i < len; i++) begin
      int m;
      if (int'($urandom_range(99)) < bad_pct) m = int'($urandom_range(3));
      else begin
        do m = int'($urandom_range(3)); while (!legal(r, c, m));
      end
      mem[i] = 2'(m);
      if (legal(r, c, m)) begin
        case (m)
          0:       r--;
          1:       c++;
          2:       c--;
          default: r++;
        endcase
      end
    end
  endtask

  task automatic gen_dest();
    int rt = 15;
    int dn = 15;
    for (int i = 0; i < 30; i++) begin
      if (int'($urandom_range(rt + dn - 1)) < rt) begin mem[i] = 2'b01; rt--; end
      else begin mem[i] = 2'b11; dn--; end
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_move"}, move, 0);
    check({tag, "_valid"}, move_valid, 0);
    check({tag, "_pos"}, pos, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fail"}, fail, 0);
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 ready held low 5 cycles per move.
  task automatic replay(input int dep, input int rmode, input string tag);
    int  ehs, ep, k, cyc, vrun, budget, n;
    bit  edn, pend;
    n = (dep > 256) ? 256 : dep;
    model(n, ehs, edn, ep);
    k = 0; vrun = 0; pend = 1'b0;
    budget = 10 * n + 20;
    depth = (AW+1)'(dep);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    cyc = 1;
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_clear"}, {done, fail}, 0);
    while (!(done || fail) && cyc < budget) begin
      if (move_valid) begin
        if (k >= ehs) check({tag, "_extra_valid"}, 1, 0);
        else begin
          check({tag, "_move"}, move, exp_mv[k]);
          check({tag, "_pos"}, pos, exp_pb[k]);
          if (rmode == 0 && vrun == 0) check({tag, "_lat"}, cyc, 3 * (k + 1));
        end
        vrun++;
        case (rmode)
          0:       move_ready = 1'b1;
          1:       move_ready = 1'($urandom_range(1));
          default: move_ready = (vrun > 5);
        endcase
        if (move_ready) begin k++; vrun = 0; end
      end else begin
        if (pend) check({tag, "_valid_drop"}, 0, 1);
        move_ready = 1'($urandom_range(1));
      end
      pend = move_valid && !move_ready;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= budget) check({tag, "_timeout"}, 0, 1);
    check({tag, "_hs"}, k, ehs);
    check({tag, "_done"}, done, edn);
    check({tag, "_fail"}, fail, !edn);
    check({tag, "_endpos"}, pos, ep);
    check({tag, "_busy_end"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_hold"}, {done, fail, pos}, {edn, !edn, 8'(ep)});
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; depth = '0; move_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("reset");

    // Empty stack: DEST_ADDR=0 instance completes, default instance fails, two cycles after run.
    depth = '0; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    check("empty_busy", d0_busy, 1);
    check("empty_early", {d0_done, d0_fail}, 0);
    @(posedge clk); #1;
    check("empty_d0", {d0_done, d0_fail, d0_valid, d0_busy}, 4'b1000);
    check("empty_main", {done, fail, move_valid, busy}, 4'b0100);

    for (int i = 0; i < 30; i++) mem[i] = (i < 15) ? 2'b01 : 2'b11;
    replay(30, 0, "right_down");

    mem[0] = 2'b00;
    replay(1, 1, "up_wall");

    gen_dest();
    replay(30, 2, "stall");

    for (int i = 0; i < 10; i++) mem[i] = 2'b01;
    replay(10, 0, "ten_right");
    replay(10, 1, "ten_right_again");

    // Reset while a move is on offer.
    gen_walk(40, 0);
    depth = 9'd40; run = 1'b1; move_ready = 1'b0;
    @(posedge clk); #1;
    run = 1'b0;
    for (int i = 0; i < 20 && !move_valid; i++) begin @(posedge clk); #1; end
    check("abort_valid", move_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("abort");
    replay(40, 1, "restart");

    gen_walk(256, 0);
    replay(300, 0, "clamp");

    for (int t = 0; t < 12; t++) begin
      int len;
      if ($urandom_range(2) == 0) begin gen_dest(); len = 30; end
      else begin len = int'($urandom_range(40, 1)); gen_walk(len, 5); end
      replay(len, int'($urandom_range(2)), $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
